fsm_vector_sequencer: RTL and testbench
=======================================

Name: fsm_vector_sequencer

Overview:
Upstream stimulus stage for the 2-state Moore FSM block. Holds a programmable 2-state x 2-input transition table and a per-state 4-bit output table. Walks the table with LFSR-generated input bits and drives in/cs/ns/exp_out vectors, one per handshake, into the FSM and its checker. It also issues the FSM's reset pulse so its tracked state matches the FSM's ZERO state at run start.

Parameters:
OUT_W, 4, width of exp_out and of output-table entries
CNT_W, 16, width of the vector count and num_vectors
LFSR_SEED, 8'hA5, nonzero seed loaded into the input LFSR on every start

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
cfg_we  input  1  write strobe for ns table entry at cfg_addr
cfg_addr  input  2  {state, in} table index
cfg_ns  input  1  next-state value written at cfg_addr
cfg_owe  input  1  write strobe for output table entry cfg_addr[1]
cfg_out  input  OUT_W  Moore output value for state cfg_addr[1]
start  input  1  begin a run (IDLE only)
num_vectors  input  CNT_W  vectors to issue, sampled on start
vec_ready  input  1  downstream accepts the current vector
dut_reset  output  1  reset pulse to the FSM
vec_valid  output  1  in/cs/ns/exp_out are valid
in  output  1  stimulus input bit
cs  output  1  current state tracked by the sequencer
ns  output  1  table next state for (cs, in)
exp_out  output  OUT_W  table output for cs
busy  output  1  run in progress
done  output  1  one-cycle pulse at end of run
vec_count  output  CNT_W  vectors accepted in the current or last run

Behaviour:
- Reset: state IDLE; cs=0; lfsr=LFSR_SEED; vec_count=0; vec_valid=0, dut_reset=0, busy=0, done=0.
- Reset table contents: ns_tbl[{s,i}] = i; out_tbl[0] = 0, out_tbl[1] = all ones.
- Config writes apply in the cycle after the strobe, and only in IDLE. Writes are ignored while busy.
- cfg_we and cfg_owe may be asserted in the same cycle; both writes apply.
- FSM states: IDLE, RSTP, RUN, DONE.
- IDLE, start=1: latch num_vectors into remaining; lfsr <= LFSR_SEED; cs <= 0; vec_count <= 0; go to RSTP.
- RSTP: dut_reset=1 for exactly one cycle; busy=1. Next state is DONE if remaining==0, else RUN.
- RUN: vec_valid=1; busy=1; in=lfsr[0]; ns=ns_tbl[{cs,in}]; exp_out=out_tbl[cs] (combinational from registered cs and lfsr).
- Handshake is vec_valid && vec_ready. On a handshake: cs<=ns; lfsr advances one step; vec_count++; remaining--.
  - If remaining was 1, go to DONE; vec_valid drops the next cycle.
- Backpressure: with vec_ready=0, all vector outputs stay stable and nothing advances. There is no combinational path from vec_ready to vec_valid.
- DONE: done=1 for one cycle, busy=0; go to IDLE. vec_count holds until the next start.
- start outside IDLE is ignored.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Shift left; new bit0 = b7^b5^b4^b3.
- Latency: first vector valid 2 cycles after start is sampled (start -> RSTP -> RUN). One vector per cycle when vec_ready is held high.
- Reset mid-run: returns to reset values immediately. No done pulse; dut_reset stays 0.
- vec_count wraps at 2^CNT_W only if num_vectors does (it cannot exceed num_vectors).

Decomposition:
- Shared package fsm_tb_pkg: state enum {IDLE, RSTP, RUN, DONE}; constants ST_ZERO=0, ST_ONE=1; OUT_W default; LFSR taps and seed.
- One natural sub-module: lfsr8 (enable, load, seed; outputs the 8-bit value).
- Table and control logic stay in fsm_vector_sequencer.

Test Plan:
- Reset, then start with num_vectors=4 and vec_ready=1 -> dut_reset high in cycle 1 only; vec_valid cycles 2-5; in = 1,0,1,0 (lfsr 0xA5 -> 0x4A -> 0x95 -> 0x2A); ns = in; exp_out = 0 when cs=0, 0xF when cs=1; done pulse in cycle 6; vec_count=4.
- Program ns_tbl to toggle (ns = ~cs for both inputs), out_tbl[0]=3, out_tbl[1]=C; run 3 vectors -> cs = 0,1,0; exp_out = 3,C,3.
- Run 5 vectors with vec_ready low on 2nd and 4th valid cycles -> outputs held stable during stalls; exactly 5 handshakes; done 8 cycles after RSTP.
- num_vectors=0 -> RSTP then DONE; vec_valid never asserted; done pulses once; vec_count=0.
- cfg_we and start asserted while busy -> table unchanged and run unaffected. Assert reset at 2nd vector -> all outputs at reset values next cycle; no done pulse.
- Two back-to-back runs of 3 vectors -> identical in sequences (LFSR reseeded); vec_count resets to 0 at the second start.

Source files
------------

// File: rtl/fsm_tb_pkg.sv
// Shared definitions for the FSM stimulus sequencer.
//   seq_state_e   : sequencer control states
//   ST_ZERO/ONE   : encodings of the target FSM's two states
//   OUT_W_DEF     : default Moore output width
//   LFSR_*        : seed and tap mask of the 8-bit stimulus LFSR
//   lfsr_step()   : one Fibonacci shift (shift left, feedback into bit 0)
package fsm_tb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RSTP,
        RUN,
        DONE
    } seq_state_e;

    localparam logic ST_ZERO = 1'b0;
    localparam logic ST_ONE  = 1'b1;

    localparam int unsigned OUT_W_DEF = 4;

    // x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/fsm_vector_sequencer_lfsr8.sv
// 8-bit Fibonacci LFSR producing stimulus input bits.
//   clk, reset : clock, synchronous active-high reset (loads seed)
//   load       : reload seed (has priority over enable)
//   enable     : advance one step
//   seed       : value loaded on reset/load
//   value      : current register contents
module lfsr8
    import fsm_tb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       enable,
    input  logic [7:0] seed,
    output logic [7:0] value
);

    logic [7:0] value_q;
    logic [7:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = seed;
        end else if (enable) begin
            value_d = lfsr_step(value_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= seed;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/fsm_vector_sequencer.sv
// Stimulus sequencer for a 2-state Moore FSM and its checker.
// Holds a programmable next-state table (indexed {state,in}) and a
// per-state output table, walks them with LFSR input bits and issues
// one in/cs/ns/exp_out vector per valid/ready handshake.
//   cfg_we/cfg_addr/cfg_ns : next-state table write (IDLE only)
//   cfg_owe/cfg_out        : output table write at cfg_addr[1] (IDLE only)
//   start/num_vectors      : begin a run of num_vectors vectors
//   vec_valid/vec_ready    : vector handshake
//   in/cs/ns/exp_out       : vector contents
//   dut_reset              : one-cycle reset pulse to the target FSM
//   busy/done/vec_count    : run status
module fsm_vector_sequencer
    import fsm_tb_pkg::*;
#(
    parameter int unsigned OUT_W     = OUT_W_DEF,
    parameter int unsigned CNT_W     = 16,
    parameter logic [7:0]  LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic             cfg_ns,
    input  logic             cfg_owe,
    input  logic [OUT_W-1:0] cfg_out,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             vec_ready,
    output logic             dut_reset,
    output logic             vec_valid,
    output logic             in,
    output logic             cs,
    output logic             ns,
    output logic [OUT_W-1:0] exp_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_count
);

    seq_state_e       state_q, state_d;
    logic             cs_q, cs_d;
    logic [CNT_W-1:0] vec_count_q, vec_count_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [3:0]       ns_tbl_q, ns_tbl_d;
    logic [OUT_W-1:0] out_tbl_q [2];
    logic [OUT_W-1:0] out_tbl_d [2];

    logic       lfsr_load;
    logic       lfsr_en;
    logic [7:0] lfsr_value;
    logic       in_bit;
    logic       ns_bit;
    logic       handshake;

    lfsr8 u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .load   (lfsr_load),
        .enable (lfsr_en),
        .seed   (LFSR_SEED),
        .value  (lfsr_value)
    );

    // Vector fields come only from registered state, so vec_ready never
    // reaches vec_valid or the vector contents combinationally.
    assign in_bit    = lfsr_value[0];
    assign ns_bit    = ns_tbl_q[{cs_q, in_bit}];
    assign handshake = (state_q == RUN) && vec_ready;

    always_comb begin
        state_d     = state_q;
        cs_d        = cs_q;
        vec_count_d = vec_count_q;
        remaining_d = remaining_q;
        ns_tbl_d    = ns_tbl_q;
        out_tbl_d   = out_tbl_q;
        lfsr_load   = 1'b0;
        lfsr_en     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    ns_tbl_d[cfg_addr] = cfg_ns;
                end
                if (cfg_owe) begin
                    out_tbl_d[cfg_addr[1]] = cfg_out;
                end
                if (start) begin
                    remaining_d = num_vectors;
                    lfsr_load   = 1'b1;
                    cs_d        = ST_ZERO;
                    vec_count_d = '0;
                    state_d     = RSTP;
                end
            end
            RSTP: begin
                state_d = (remaining_q == '0) ? DONE : RUN;
            end
            RUN: begin
                if (handshake) begin
                    cs_d        = ns_bit;
                    lfsr_en     = 1'b1;
                    vec_count_d = vec_count_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cs_q         <= ST_ZERO;
            vec_count_q  <= '0;
            remaining_q  <= '0;
            ns_tbl_q     <= 4'b1010;  // ns = in for both states
            out_tbl_q[0] <= '0;
            out_tbl_q[1] <= '1;
        end else begin
            state_q      <= state_d;
            cs_q         <= cs_d;
            vec_count_q  <= vec_count_d;
            remaining_q  <= remaining_d;
            ns_tbl_q     <= ns_tbl_d;
            out_tbl_q[0] <= out_tbl_d[0];
            out_tbl_q[1] <= out_tbl_d[1];
        end
    end

    always_comb begin
        dut_reset = (state_q == RSTP);
        vec_valid = (state_q == RUN);
        busy      = (state_q == RSTP) || (state_q == RUN);
        done      = (state_q == DONE);
        in        = in_bit;
        cs        = cs_q;
        ns        = ns_bit;
        exp_out   = out_tbl_q[cs_q];
        vec_count = vec_count_q;
    end

endmodule

// File: tb/tb_fsm_vector_sequencer.sv
module tb_fsm_vector_sequencer;

    localparam int OUT_W = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic             cfg_ns;
    logic             cfg_owe;
    logic [OUT_W-1:0] cfg_out;
    logic             start;
    logic [CNT_W-1:0] num_vectors;
    logic             vec_ready;
    logic             dut_reset;
    logic             vec_valid;
    logic             in_o;
    logic             cs_o;
    logic             ns_o;
    logic [OUT_W-1:0] exp_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] vec_count;

    fsm_vector_sequencer #(
        .OUT_W     (OUT_W),
        .CNT_W     (CNT_W),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_ns      (cfg_ns),
        .cfg_owe     (cfg_owe),
        .cfg_out     (cfg_out),
        .start       (start),
        .num_vectors (num_vectors),
        .vec_ready   (vec_ready),
        .dut_reset   (dut_reset),
        .vec_valid   (vec_valid),
        .in          (in_o),
        .cs          (cs_o),
        .ns          (ns_o),
        .exp_out     (exp_out),
        .busy        (busy),
        .done        (done),
        .vec_count   (vec_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             in;
        logic             cs;
        logic             ns;
        logic [OUT_W-1:0] eo;
    } vec_t;

    vec_t sb[$];

    // Reference copies of the tables, updated alongside every IDLE write.
    logic [3:0]       m_ns;
    logic [OUT_W-1:0] m_out [2];

    int checks = 0;
    int errors = 0;

    int r_rst_cyc, r_rst_cnt, r_first_valid, r_valid, r_hs;
    int r_done_cyc, r_done_cnt, r_vc_done, r_vc1;
    bit r_was_reset;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic void model_reset_tables();
        m_ns     = 4'b1010;
        m_out[0] = 4'h0;
        m_out[1] = 4'hF;
    endfunction

    function automatic void push_expected(input int n);
        logic [7:0] l;
        logic       c;
        vec_t       v;
        l = 8'hA5;
        c = 1'b0;
        for (int k = 0; k < n; k++) begin
            v.in = l[0];
            v.cs = c;
            v.ns = m_ns[{c, l[0]}];
            v.eo = m_out[c];
            sb.push_back(v);
            c = v.ns;
            l = model_step(l);
        end
    endfunction

    task automatic cfg_write(input logic [1:0] a, input bit we, input logic nsv,
                             input bit owe, input logic [OUT_W-1:0] ov);
        cfg_we   = we;
        cfg_owe  = owe;
        cfg_addr = a;
        cfg_ns   = nsv;
        cfg_out  = ov;
        tick();
        cfg_we  = 1'b0;
        cfg_owe = 1'b0;
        if (we)  m_ns[a]     = nsv;
        if (owe) m_out[a[1]] = ov;
    endtask

    // Start a run and follow it cycle by cycle (cycle 1 = first after start
    // is sampled). stall_mask bit k drops vec_ready on the k-th valid cycle.
    task automatic run(input int n, input int stall_mask, input bit poke, input int rst_at);
        int   vidx;
        bit   prev_stall;
        vec_t saved, got, e;
        vidx = 0;
        prev_stall = 1'b0;
        saved = '0;
        r_rst_cyc = -1; r_rst_cnt = 0; r_first_valid = -1; r_valid = 0; r_hs = 0;
        r_done_cyc = -1; r_done_cnt = 0; r_vc_done = -1; r_vc1 = -1; r_was_reset = 1'b0;
        push_expected(n);
        num_vectors = CNT_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        num_vectors = CNT_W'($urandom_range(50, 200));
        for (int c = 1; c <= 64; c++) begin
            cfg_we = 1'b0;
            cfg_owe = 1'b0;
            start = 1'b0;
            vec_ready = 1'b1;
            if (vec_valid) begin
                vidx++;
                if (stall_mask[vidx]) vec_ready = 1'b0;
                if (poke && vidx == 1) begin
                    start = 1'b1;
                    num_vectors = CNT_W'(9);
                    cfg_we = 1'b1;
                    cfg_addr = 2'b01;
                    cfg_ns = ~m_ns[1];
                    cfg_owe = 1'b1;
                    cfg_out = ~m_out[0];
                end
                if (vidx == rst_at) reset = 1'b1;
            end
            @(negedge clk);
            got = {in_o, cs_o, ns_o, exp_out};
            if (dut_reset) begin
                r_rst_cnt++;
                if (r_rst_cyc < 0) r_rst_cyc = c;
            end
            if (c == 1) r_vc1 = int'(vec_count);
            if (prev_stall) begin
                check("stall_valid", vec_valid, 1'b1);
                check("stall_vec", got, saved);
            end
            prev_stall = vec_valid && !vec_ready;
            saved = got;
            if (vec_valid) begin
                r_valid++;
                if (r_first_valid < 0) r_first_valid = c;
            end
            if (vec_valid && vec_ready) begin
                r_hs++;
                if (sb.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("vec_in", got.in, e.in);
                    check("vec_cs", got.cs, e.cs);
                    check("vec_ns", got.ns, e.ns);
                    check("vec_exp_out", got.eo, e.eo);
                end
            end
            if (done) begin
                r_done_cnt++;
                r_done_cyc = c;
                r_vc_done = int'(vec_count);
            end
            tick();
            if (reset) begin
                reset = 1'b0;
                r_was_reset = 1'b1;
                break;
            end
            if (r_done_cyc >= 0) break;
        end
        cfg_we = 1'b0;
        cfg_owe = 1'b0;
        start = 1'b0;
        vec_ready = 1'b1;
        if (!r_was_reset) begin
            if (r_done_cyc < 0) check("timeout", 0, 1);
            @(negedge clk);
            check("done_one_cycle", done, 1'b0);
            check("idle_not_busy", busy, 1'b0);
            check("sb_drained", sb.size(), 0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        @(negedge clk);
        check({tag, "_valid"}, vec_valid, 1'b0);
        check({tag, "_dut_reset"}, dut_reset, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_cs"}, cs_o, 1'b0);
        check({tag, "_in"}, in_o, 1'b1);
        check({tag, "_exp_out"}, exp_out, 4'h0);
        check({tag, "_vec_count"}, vec_count, 0);
    endtask

    initial begin
        reset = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_ns = 1'b0;
        cfg_owe = 1'b0; cfg_out = '0;
        start = 1'b0; num_vectors = '0; vec_ready = 1'b1;
        model_reset_tables();
        tick();
        tick();
        reset = 1'b0;
        check_reset_values("rst");

        // Default table, 4 vectors, ready held high
        tick();
        run(4, 0, 1'b0, 0);
        check("t1_rst_cyc", r_rst_cyc, 1);
        check("t1_rst_cnt", r_rst_cnt, 1);
        check("t1_first_valid", r_first_valid, 2);
        check("t1_valid_cnt", r_valid, 4);
        check("t1_done_cyc", r_done_cyc, 6);
        check("t1_vec_count", r_vc_done, 4);
        check("t1_vec_count_hold", vec_count, 4);

        // Toggle table with custom outputs; paired writes in one cycle
        tick();
        cfg_write(2'b00, 1'b1, 1'b1, 1'b1, 4'h3);
        cfg_write(2'b01, 1'b1, 1'b1, 1'b0, 4'h0);
        cfg_write(2'b10, 1'b1, 1'b0, 1'b1, 4'hC);
        cfg_write(2'b11, 1'b1, 1'b0, 1'b0, 4'h0);
        run(3, 0, 1'b0, 0);
        check("t2_done_cyc", r_done_cyc, 5);
        check("t2_vec_count", r_vc_done, 3);

        // Backpressure on 2nd and 4th valid cycles
        tick();
        run(5, (1 << 2) | (1 << 4), 1'b0, 0);
        check("t3_hs", r_hs, 5);
        check("t3_valid_cnt", r_valid, 7);
        check("t3_done_after_rstp", r_done_cyc - r_rst_cyc, 8);

        // Zero-length run
        tick();
        run(0, 0, 1'b0, 0);
        check("t4_rst_cnt", r_rst_cnt, 1);
        check("t4_valid_cnt", r_valid, 0);
        check("t4_done_cyc", r_done_cyc, 2);
        check("t4_done_cnt", r_done_cnt, 1);
        check("t4_vec_count", r_vc_done, 0);

        // Config writes and start while busy must have no effect
        tick();
        run(4, 0, 1'b1, 0);
        check("t5_hs", r_hs, 4);
        check("t5_done_cyc", r_done_cyc, 6);
        check("t5_vec_count", r_vc_done, 4);

        // Same table again confirms the busy writes were dropped; reset at 2nd vector
        tick();
        run(4, 0, 1'b0, 2);
        check("t6_was_reset", r_was_reset, 1'b1);
        sb.delete();
        model_reset_tables();
        check_reset_values("midrst");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("midrst_no_done", done, 1'b0);
            check("midrst_no_dut_reset", dut_reset, 1'b0);
        end

        // Back-to-back runs, LFSR reseeded, tables back at reset contents
        tick();
        run(3, 0, 1'b0, 0);
        check("t7a_vec_count", r_vc_done, 3);
        run(3, 0, 1'b0, 0);
        check("t7b_vc_cleared", r_vc1, 0);
        check("t7b_vec_count", r_vc_done, 3);
        check("t7b_done_cyc", r_done_cyc, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
